axis_sample_pacer: RTL and testbench

Rate-paced AXI-Stream sample transmitter that feeds the bandpass FIR input (`s_axis_*` of the filter) at a fixed sample rate, 500 Hz at a 50 MHz clock by default. A producer such as an ADC front end or a processor writes samples into an internal FIFO at any rate. A programmable tick divider releases exactly one sample per tick onto an AXIS master port. The block replaces ad-hoc stimulus pacing and sits directly upstream of the filter in the ECG datapath.

---
 rtl/axis_sample_pacer.sv | 168 ++++++++++++++++
 tb/tb_axis_sample_pacer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_pacer.sv
// Rate-paced AXI-Stream sample transmitter: FIFO-buffered producer samples released one per DIV-cycle tick.
// Optional build macro PACER_ZERO_FILL_EN: empty ticks emit a zero-valued transfer instead of nothing.
module axis_sample_pacer #(
  parameter int DATA_W = 16,
  parameter int DIV    = 100000,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                underflow_cnt,
  output logic                       overrun
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [15:0]         underflow_q, underflow_d;
  logic                overrun_q, overrun_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic tick;
  logic fifo_empty;
  logic wr_en;
  logic pop;

  assign tick       = (cnt_q == CNT_W'(DIV - 1));
  assign fifo_empty = (level_q == '0);
  assign wr_ready   = (level_q != LVL_W'(DEPTH));
  assign wr_en      = wr_valid && wr_ready;

  // Sample storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    underflow_d = underflow_q;
    overrun_d   = overrun_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        if (enable) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            tdata_d  = mem[rd_ptr_q];
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
          end else begin
            if (underflow_q != 16'hFFFF) begin
              underflow_d = underflow_q + 16'd1;
            end
`ifdef PACER_ZERO_FILL_EN
            tdata_d  = '0;
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
`endif
          end
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // The transfer in flight cannot be abandoned, so a tick here is simply lost.
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = enable ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_q == ST_IDLE || state_d == ST_IDLE || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      underflow_q <= '0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      underflow_q <= underflow_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign fifo_level    = level_q;
  assign underflow_cnt = underflow_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_sample_pacer.sv
// Directed bench for axis_sample_pacer with DIV=8, DEPTH=4; inputs driven and outputs sampled on the falling edge.
module tb_axis_sample_pacer;

  localparam int DATA_W = 16;
  localparam int DIV    = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [2:0]        fifo_level;
  logic [15:0]       underflow_cnt;
  logic              overrun;

  int vectors;
  int miscompares;
  int n;

  axis_sample_pacer #(.DATA_W(DATA_W), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = '0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Steps falling edges until tvalid is seen or the budget runs out; returns the step count.
  task automatic wait_pulse(input int max_steps, output int steps);
    steps = 0;
    do begin
      @(negedge clk);
      steps++;
    end while (!m_axis_tvalid && steps < max_steps);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    enable        = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = '0;
    m_axis_tready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_underflow", 32'(underflow_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    apply_reset();

    // Four samples, paced output with tready high
    wr(16'h7FFF); wr(16'h0000); wr(16'h0000); wr(16'h0000);
    chk("t1_level_full", 32'(fifo_level), 32'd4);
    chk("t1_wr_ready_full", 32'(wr_ready), 32'd0);
    enable = 1'b1; m_axis_tready = 1'b1;
    wait_pulse(20, n);
    chk("t1_first_latency", 32'(n), 32'd9);
    chk("t1_d0", 32'(m_axis_tdata), 32'h7FFF);
    chk("t1_level_after_pop", 32'(fifo_level), 32'd3);
    @(negedge clk);
    chk("t1_single_cycle", 32'(m_axis_tvalid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      wait_pulse(20, n);
      chk("t1_period", 32'(n), 32'd7);
      chk("t1_data", 32'(m_axis_tdata), 32'h0000);
      @(negedge clk);
    end
    enable = 1'b0;
    chk("t1_level_empty", 32'(fifo_level), 32'd0);
    chk("t1_no_underflow", 32'(underflow_cnt), 32'd0);
    apply_reset();

    // Six writes into a depth-4 FIFO: last two dropped
    wr(16'h0A01); chk("t2_ready1", 32'(wr_ready), 32'd1);
    wr(16'h0A02); chk("t2_ready2", 32'(wr_ready), 32'd1);
    wr(16'h0A03); chk("t2_ready3", 32'(wr_ready), 32'd1);
    wr(16'h0A04); chk("t2_ready4", 32'(wr_ready), 32'd0);
    wr(16'h0A05); chk("t2_level5", 32'(fifo_level), 32'd4);
    wr(16'h0A06); chk("t2_level6", 32'(fifo_level), 32'd4);
    enable = 1'b1; m_axis_tready = 1'b1;
    wait_pulse(20, n);
    chk("t2_first_latency", 32'(n), 32'd9);
    chk("t2_d1", 32'(m_axis_tdata), 32'h0A01);
    wait_pulse(20, n); chk("t2_d2", 32'(m_axis_tdata), 32'h0A02);
    wait_pulse(20, n); chk("t2_d3", 32'(m_axis_tdata), 32'h0A03);
    wait_pulse(20, n); chk("t2_d4", 32'(m_axis_tdata), 32'h0A04);
    chk("t2_period", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_no_fifth", 32'(m_axis_tvalid), 32'd0);
    end
    chk("t2_underflow", 32'(underflow_cnt), 32'd1);
    apply_reset();

    // Stalled transfer: tick lost, overrun set, one pop only
    wr(16'h1111); wr(16'h2222);
    enable = 1'b1; m_axis_tready = 1'b0;
    wait_pulse(20, n);
    chk("t3_first_latency", 32'(n), 32'd9);
    chk("t3_d1", 32'(m_axis_tdata), 32'h1111);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("t3_hold_data", 32'(m_axis_tdata), 32'h1111);
    end
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_one_pop", 32'(fifo_level), 32'd1);
    m_axis_tready = 1'b1;
    wait_pulse(20, n);
    chk("t3_next_tick", 32'(n), 32'd4);
    chk("t3_d2", 32'(m_axis_tdata), 32'h2222);
    chk("t3_overrun_sticky", 32'(overrun), 32'd1);
    apply_reset();

    // Empty FIFO for three ticks
    enable = 1'b1; m_axis_tready = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
`ifdef PACER_ZERO_FILL_EN
      chk("t4_zero_fill_valid", 32'(m_axis_tvalid), (k == 9 || k == 17 || k == 25) ? 32'd1 : 32'd0);
      chk("t4_zero_fill_data", 32'(m_axis_tdata), 32'd0);
`else
      chk("t4_no_valid", 32'(m_axis_tvalid), 32'd0);
`endif
    end
    chk("t4_underflow", 32'(underflow_cnt), 32'd3);
    chk("t4_no_overrun", 32'(overrun), 32'd0);
    apply_reset();

    // Disable while stalled in SEND
    wr(16'h0C01); wr(16'h0C02);
    enable = 1'b1; m_axis_tready = 1'b0;
    wait_pulse(20, n);
    chk("t5_latency", 32'(n), 32'd9);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(m_axis_tvalid), 32'd1);
      chk("t5_hold_data", 32'(m_axis_tdata), 32'h0C01);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_idle_no_pulse", 32'(m_axis_tvalid), 32'd0);
    end
    chk("t5_level", 32'(fifo_level), 32'd1);
    chk("t5_underflow", 32'(underflow_cnt), 32'd0);
    apply_reset();

    // Asynchronous reset mid-SEND
    wr(16'h0D01); wr(16'h0D02); wr(16'h0D03);
    enable = 1'b1; m_axis_tready = 1'b0;
    wait_pulse(20, n);
    chk("t6_latency", 32'(n), 32'd9);
    chk("t6_level_before", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("t6_rst_underflow", 32'(underflow_cnt), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t6_no_pulse_empty", 32'(m_axis_tvalid), 32'd0);
    end
    chk("t6_underflow", 32'(underflow_cnt), 32'd1);
    wr_valid = 1'b1; wr_data = 16'h0D04;
    @(negedge clk);
    wr_valid = 1'b0;
    n = 1;
    while (!m_axis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pulse_after_write", 32'(n), 32'd8);
    chk("t6_data", 32'(m_axis_tdata), 32'h0D04);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
